// File: rtl/spy_path_delay_meter.sv
// Launch/capture controller for a chained spy delay path: toggles pathInput, synchronises pathResult
// and counts clk cycles per sample, reporting sum and worst-case delay over a valid/ready handshake.
module spy_path_delay_meter #(
   parameter int NUM_SAMPLES  = 16,
   parameter int CNT_W        = 16,
   parameter int TIMEOUT      = 1023,
   parameter int SYNC_STAGES  = 2,
   parameter int PATH_INVERTS = 0
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   start,
   output logic                                   busy,
   output logic                                   pathInput,
   input  logic                                   pathResult,
   output logic                                   result_valid,
   input  logic                                   result_ready,
   output logic [CNT_W+$clog2(NUM_SAMPLES)-1:0]   delay_sum,
   output logic [CNT_W-1:0]                       delay_max,
   output logic                                   timeout_err
);

   localparam int IDX_W = $clog2(NUM_SAMPLES);
   localparam int SUM_W = CNT_W + IDX_W;
   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
   localparam logic INV = (PATH_INVERTS != 0);

   typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, WAIT, DONE} state_t;

   state_t                  state, state_nxt;
   logic                    path_nxt;
   logic [SYNC_STAGES-1:0]  sync;
   logic [CNT_W-1:0]        count, count_nxt;
   logic [IDX_W-1:0]        idx, idx_nxt;
   logic [SUM_W-1:0]        sum_nxt;
   logic [CNT_W-1:0]        max_nxt;
   logic                    err_nxt;
   logic                    match;
   logic [CNT_W-1:0]        sample;

   assign match = (sync[SYNC_STAGES-1] == (pathInput ^ INV));
   // The match cycle itself counts, so a zero-delay loopback records SYNC_STAGES+1.
   assign sample = (count == TMO) ? TMO : count + 1'b1;

   assign busy         = (state == SETTLE) || (state == LAUNCH) || (state == WAIT);
   assign result_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pathInput   <= 1'b0;
         sync        <= '0;
         count       <= '0;
         idx         <= '0;
         delay_sum   <= '0;
         delay_max   <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         pathInput   <= path_nxt;
         sync        <= {sync[SYNC_STAGES-2:0], pathResult};
         count       <= count_nxt;
         idx         <= idx_nxt;
         delay_sum   <= sum_nxt;
         delay_max   <= max_nxt;
         timeout_err <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      path_nxt  = pathInput;
      count_nxt = count;
      idx_nxt   = idx;
      sum_nxt   = delay_sum;
      max_nxt   = delay_max;
      err_nxt   = timeout_err;
      case (state)
         IDLE: begin
            if (start) begin
               sum_nxt   = '0;
               max_nxt   = '0;
               err_nxt   = 1'b0;
               idx_nxt   = '0;
               count_nxt = '0;
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (match) begin
               state_nxt = LAUNCH;
            end else if (count == TMO) begin
               err_nxt   = 1'b1;
               state_nxt = DONE;
            end else begin
               count_nxt = count + 1'b1;
            end
         end
         LAUNCH: begin
            path_nxt  = ~pathInput;
            count_nxt = '0;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (match) begin
               sum_nxt   = delay_sum + SUM_W'(sample);
               max_nxt   = (sample > delay_max) ? sample : delay_max;
               idx_nxt   = idx + 1'b1;
               state_nxt = (idx == LAST_IDX) ? DONE : LAUNCH;
            end else if (count == TMO) begin
               err_nxt   = 1'b1;
               state_nxt = DONE;
            end else begin
               count_nxt = count + 1'b1;
            end
         end
         DONE: begin
            if (result_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_spy_path_delay_meter.sv
// Scoreboard bench for spy_path_delay_meter: directed measurements over loopback, delayed,
// stuck and inverted paths; a monitor pops expected results on each result handshake.
module tb_spy_path_delay_meter;

   localparam int SUM_W = 20;

   typedef struct {
      int sum;
      int mx;
      int err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // Normal instance
   logic             start = 1'b0;
   logic             result_ready = 1'b1;
   logic             busy, path_in, result_valid, timeout_err;
   logic             path_res;
   logic [SUM_W-1:0] delay_sum;
   logic [15:0]      delay_max;

   // Inverting-path instance
   logic             start2 = 1'b0;
   logic             busy2, path_in2, result_valid2, timeout_err2;
   logic [SUM_W-1:0] delay_sum2;
   logic [15:0]      delay_max2;

   int   mode = 0;          // 0 loopback, 1 five-cycle delay, 2 stuck low
   logic [4:0] dly = '0;
   int   checks = 0;
   int   fails = 0;
   int   toggles = 0;
   logic pi_last = 1'b0;
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   // Model of the delay path: a 5-flop line gives five extra full cycles.
   always @(posedge clk) dly <= {dly[3:0], path_in};
   assign path_res = (mode == 0) ? path_in : (mode == 1) ? dly[4] : 1'b0;

   spy_path_delay_meter dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .pathInput(path_in),
      .pathResult(path_res), .result_valid(result_valid), .result_ready(result_ready),
      .delay_sum(delay_sum), .delay_max(delay_max), .timeout_err(timeout_err)
   );

   spy_path_delay_meter #(.PATH_INVERTS(1)) dut_inv (
      .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .pathInput(path_in2),
      .pathResult(~path_in2), .result_valid(result_valid2), .result_ready(1'b1),
      .delay_sum(delay_sum2), .delay_max(delay_max2), .timeout_err(timeout_err2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (path_in !== pi_last) toggles++;
      pi_last = path_in;
   end

   // Monitor for the normal instance
   always @(negedge clk) begin
      if (rst_n && result_valid && result_ready) begin
         check("valid_busy_exclusive", {31'd0, busy}, 32'd0);
         if (q1.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q1.pop_front();
            check("delay_sum", 32'(delay_sum), e.sum);
            check("delay_max", 32'(delay_max), e.mx);
            check("timeout_err", {31'd0, timeout_err}, e.err);
         end
      end
   end

   // Monitor for the inverting instance
   always @(negedge clk) begin
      if (rst_n && result_valid2) begin
         if (q2.size() == 0) begin
            check("inv_unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q2.pop_front();
            check("inv_delay_sum", 32'(delay_sum2), e.sum);
            check("inv_delay_max", 32'(delay_max2), e.mx);
            check("inv_timeout_err", {31'd0, timeout_err2}, e.err);
         end
      end
   end

   task automatic pulse_start(input bit second);
      @(posedge clk); #1;
      if (second) start2 = 1'b1; else start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic wait_done(input bit second, input int bound, input string name);
      int n = 0;
      @(negedge clk);
      while (!(second ? result_valid2 : result_valid) && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (!(second ? result_valid2 : result_valid)) begin
         fails++;
         checks++;
         $display("FAIL %s: result_valid not seen within %0d cycles", name, bound);
      end
   endtask

   task automatic run(input int s, input int m, input int e, input int bound, input string name);
      q1.push_back('{s, m, e});
      pulse_start(1'b0);
      wait_done(1'b0, bound, name);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int base;
      // Reset state
      #1;
      check("rst_pathInput", {31'd0, path_in}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_valid", {31'd0, result_valid}, 32'd0);
      check("rst_sum", 32'(delay_sum), 32'd0);
      check("rst_max", 32'(delay_max), 32'd0);
      check("rst_err", {31'd0, timeout_err}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: zero-delay loopback
      mode = 0;
      run(48, 3, 0, 400, "t1_loopback");

      // 2: five-cycle path delay
      @(posedge clk); #1 mode = 1;
      base = toggles;
      run(128, 8, 0, 600, "t2_delay5");
      check("t2_toggles", 32'(toggles - base), 32'd16);

      // 3: stuck path times out in the first sample
      @(posedge clk); #1 mode = 2;
      run(0, 0, 1, 1300, "t3_stuck");

      // 4: held result, start ignored while DONE
      @(posedge clk); #1 mode = 0; result_ready = 1'b0;
      q1.push_back('{48, 3, 0});
      pulse_start(1'b0);
      wait_done(1'b0, 400, "t4_hold");
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1 start = (i == 3);
         @(negedge clk);
         check("t4_valid_held", {31'd0, result_valid}, 32'd1);
         check("t4_busy_low", {31'd0, busy}, 32'd0);
         check("t4_sum_frozen", 32'(delay_sum), 32'd48);
      end
      check("t4_max_frozen", 32'(delay_max), 32'd3);
      @(posedge clk); #1 result_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("t4_valid_dropped", {31'd0, result_valid}, 32'd0);
      check("t4_idle_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("t4_still_idle", {31'd0, busy}, 32'd0);

      // 5: asynchronous reset mid-measurement
      pulse_start(1'b0);
      repeat (12) @(negedge clk);
      check("t5_busy_before", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_pathInput", {31'd0, path_in}, 32'd0);
      check("t5_rst_busy", {31'd0, busy}, 32'd0);
      check("t5_rst_valid", {31'd0, result_valid}, 32'd0);
      check("t5_rst_sum", 32'(delay_sum), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      run(48, 3, 0, 400, "t5_rerun");

      // 6: inverting path with inverted loopback
      q2.push_back('{48, 3, 0});
      pulse_start(1'b1);
      wait_done(1'b1, 400, "t6_inverted");
      repeat (3) @(negedge clk);

      check("q1_drained", 32'(q1.size()), 32'd0);
      check("q2_drained", 32'(q2.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
